// File: rtl/pipeline_ctrl_pkg.sv
// Shared types, widths and helpers for the decode/execute issue controller.
package pipeline_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } pc_state_t;

  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// Outstanding-write scoreboard: one bit per architectural register, set wins over clear.
module pipeline_ctrl_reg_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_set_en,
  input  logic [REG_W-1:0]    i_set_idx,
  input  logic [NUM_REGS-1:0] i_clr_mask,
  output logic [NUM_REGS-1:0] o_pending,
  output logic [NUM_REGS-1:0] o_pending_eff
);

  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_set_mask;

  assign w_set_mask = i_set_en ? reg_bit(i_set_idx) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~i_clr_mask) | w_set_mask;
    end
  end

  // Same-cycle clears are visible to the hazard query so a retiring write never stalls.
  assign o_pending     = r_sb;
  assign o_pending_eff = r_sb & ~i_clr_mask;

endmodule

// File: rtl/pipeline_ctrl.sv
// Issue/stall/flush controller between decode and execute with register scoreboard and memory handshake.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int LINK_REG    = 15,
  parameter int FLUSH_CYC   = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_is_alu,
  input  logic                id_is_cmp,
  input  logic                id_is_jmp,
  input  logic                id_is_ld,
  input  logic                id_is_str,
  input  logic                id_is_call,
  input  logic                id_is_ret,
  input  logic                id_is_src2_imm,
  input  logic                ex_br_taken,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                mem_ack,
  output logic                issue,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_err,
  output logic [NUM_REGS-1:0] sb_pending
);

  localparam logic [REG_W-1:0] LINK_IDX   = REG_W'(LINK_REG);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  pc_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic             r_mem_str, w_mem_str_nxt;
  logic             r_mem_ld, w_mem_ld_nxt;
  logic [REG_W-1:0] r_mem_rd, w_mem_rd_nxt;

  logic                w_reads_rs, w_reads_rt, w_writes, w_mem_op;
  logic                w_hazard, w_issue, w_abort, w_stall, w_flush_id, w_flush_ex;
  logic                w_mem_busy;
  logic [REG_W-1:0]    w_dst_idx;
  logic [NUM_REGS-1:0] w_use_mask, w_clr_mask, w_pending_eff, w_sb;
  logic                w_unused_jmp;

  // JMP neither reads nor writes a register, so its flag has no effect on hazards.
  assign w_unused_jmp = id_is_jmp;

  assign w_reads_rs = id_is_alu | id_is_cmp | id_is_ld | id_is_str;
  assign w_reads_rt = (id_is_alu | id_is_cmp) & ~id_is_src2_imm;
  assign w_writes   = id_is_alu | id_is_ld | id_is_call;
  assign w_dst_idx  = id_is_call ? LINK_IDX : id_rd;
  assign w_mem_op   = id_is_ld | id_is_str;

  assign w_use_mask = (w_reads_rs ? reg_bit(id_rs)     : '0)
                    | (w_reads_rt ? reg_bit(id_rt)     : '0)
                    | (id_is_str  ? reg_bit(id_rd)     : '0)
                    | (id_is_ret  ? reg_bit(LINK_IDX)  : '0)
                    | (w_writes   ? reg_bit(w_dst_idx) : '0);

  assign w_hazard   = id_valid & (|(w_use_mask & w_pending_eff));
  assign w_issue    = id_valid & ~w_hazard & (r_state == ST_RUN) & ~ex_br_taken;
  assign w_mem_busy = (r_state == ST_MEM_WAIT);

  // An aborted load will never write back, so its destination bit is released here.
  assign w_clr_mask = (wb_valid ? reg_bit(wb_rd) : '0)
                    | ((w_abort & r_mem_ld) ? reg_bit(r_mem_rd) : '0);

  pipeline_ctrl_reg_scoreboard u_sb (
    .i_clk         (clk),
    .i_rst_n       (reset_n),
    .i_set_en      (w_issue & w_writes),
    .i_set_idx     (w_dst_idx),
    .i_clr_mask    (w_clr_mask),
    .o_pending     (w_sb),
    .o_pending_eff (w_pending_eff)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_fcnt    <= '0;
      r_tcnt    <= '0;
      r_mem_str <= 1'b0;
      r_mem_ld  <= 1'b0;
      r_mem_rd  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_mem_str <= w_mem_str_nxt;
      r_mem_ld  <= w_mem_ld_nxt;
      r_mem_rd  <= w_mem_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_tcnt_nxt    = r_tcnt;
    w_mem_str_nxt = r_mem_str;
    w_mem_ld_nxt  = r_mem_ld;
    w_mem_rd_nxt  = r_mem_rd;
    w_stall       = 1'b0;
    w_flush_id    = 1'b0;
    w_flush_ex    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall = id_valid & ~w_issue;
        if (ex_br_taken) begin
          w_flush_id  = 1'b1;
          w_flush_ex  = 1'b1;
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FLUSH_INIT;
        end else if (w_issue && w_mem_op) begin
          w_state_nxt   = ST_MEM_WAIT;
          w_tcnt_nxt    = '0;
          w_mem_str_nxt = id_is_str;
          w_mem_ld_nxt  = id_is_ld;
          w_mem_rd_nxt  = id_rd;
        end
      end
      ST_FLUSH: begin
        w_flush_id = 1'b1;
        if (r_fcnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_fcnt_nxt = r_fcnt - CNT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_state_nxt = ST_RUN;
        end else if (r_tcnt == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_tcnt_nxt = r_tcnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign issue      = w_issue;
  assign stall_if   = w_stall;
  assign stall_id   = w_stall;
  assign flush_id   = w_flush_id;
  assign flush_ex   = w_flush_ex;
  assign mem_req    = w_mem_busy;
  assign mem_we     = w_mem_busy & r_mem_str;
  assign mem_err    = w_abort;
  assign sb_pending = w_sb;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int LINK = 15;
  localparam int FCYC = 2;
  localparam int TMO  = 8;

  typedef enum int {OP_NONE, OP_ALU, OP_CMP, OP_JMP, OP_LD, OP_STR, OP_CALL, OP_RET} op_e;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [3:0]  id_rd, id_rs, id_rt;
  logic        id_is_alu, id_is_cmp, id_is_jmp, id_is_ld, id_is_str, id_is_call, id_is_ret;
  logic        id_is_src2_imm;
  logic        ex_br_taken, wb_valid, mem_ack;
  logic [3:0]  wb_rd;
  logic        issue, stall_if, stall_id, flush_id, flush_ex, mem_req, mem_we, mem_err;
  logic [15:0] sb_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: registers with an outstanding write, and what the controller is busy with.
  bit m_sb [16];
  int m_mode;        // 0 = issuing, 1 = flushing, 2 = waiting on memory
  int m_flush_left;
  int m_mem_age;     // cycles spent with the memory request raised, starting at 1
  bit m_mem_str, m_mem_ld;
  int m_mem_rd;

  always #5 clk = ~clk;

  pipeline_ctrl #(.LINK_REG(LINK), .FLUSH_CYC(FCYC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_is_alu(id_is_alu), .id_is_cmp(id_is_cmp), .id_is_jmp(id_is_jmp),
    .id_is_ld(id_is_ld), .id_is_str(id_is_str), .id_is_call(id_is_call),
    .id_is_ret(id_is_ret), .id_is_src2_imm(id_is_src2_imm),
    .ex_br_taken(ex_br_taken), .wb_valid(wb_valid), .wb_rd(wb_rd), .mem_ack(mem_ack),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex),
    .mem_req(mem_req), .mem_we(mem_we), .mem_err(mem_err), .sb_pending(sb_pending)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rd = 0; id_rs = 0; id_rt = 0;
    id_is_alu = 0; id_is_cmp = 0; id_is_jmp = 0; id_is_ld = 0;
    id_is_str = 0; id_is_call = 0; id_is_ret = 0; id_is_src2_imm = 0;
    ex_br_taken = 0; wb_valid = 0; wb_rd = 0; mem_ack = 0;
  endtask

  task automatic set_op(input op_e op, input int rd, input int rs, input int rt, input bit imm);
    id_valid = 1; id_rd = 4'(rd); id_rs = 4'(rs); id_rt = 4'(rt); id_is_src2_imm = imm;
    id_is_alu  = (op == OP_ALU);
    id_is_cmp  = (op == OP_CMP);
    id_is_jmp  = (op == OP_JMP);
    id_is_ld   = (op == OP_LD);
    id_is_str  = (op == OP_STR);
    id_is_call = (op == OP_CALL);
    id_is_ret  = (op == OP_RET);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rpick();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? LINK : r;
  endfunction

  function automatic bit pend(input int r);
    return m_sb[r] && !(wb_valid && int'(wb_rd) == r);
  endfunction

  always @(negedge clk) begin : model_cmp
    bit hz, e_issue, e_stall, e_fid, e_fex, e_req, e_we, e_err;
    int dst;
    logic [15:0] e_sb;
    if (!reset_n) begin
      for (int r = 0; r < 16; r++) m_sb[r] = 0;
      m_mode = 0; m_flush_left = 0; m_mem_age = 0;
      m_mem_str = 0; m_mem_ld = 0; m_mem_rd = 0;
    end
    hz = 0;
    if (id_is_alu || id_is_cmp || id_is_ld || id_is_str) hz |= pend(int'(id_rs));
    if ((id_is_alu || id_is_cmp) && !id_is_src2_imm) hz |= pend(int'(id_rt));
    if (id_is_str) hz |= pend(int'(id_rd));
    if (id_is_ret) hz |= pend(LINK);
    dst = -1;
    if (id_is_alu || id_is_ld) dst = int'(id_rd);
    else if (id_is_call) dst = LINK;
    if (dst >= 0) hz |= pend(dst);
    hz = hz && id_valid;
    e_issue = id_valid && !hz && (m_mode == 0) && !ex_br_taken;
    e_stall = 0; e_fid = 0; e_fex = 0; e_req = 0; e_we = 0; e_err = 0;
    case (m_mode)
      0: begin
        e_stall = id_valid && !e_issue;
        e_fid   = ex_br_taken;
        e_fex   = ex_br_taken;
      end
      1: e_fid = 1;
      default: begin
        e_stall = 1;
        e_req   = 1;
        e_we    = m_mem_str;
        e_err   = !mem_ack && (m_mem_age == TMO);
      end
    endcase
    for (int r = 0; r < 16; r++) e_sb[r] = m_sb[r];

    check1("m_issue", issue, e_issue);
    check1("m_stall_if", stall_if, e_stall);
    check1("m_stall_id", stall_id, e_stall);
    check1("m_flush_id", flush_id, e_fid);
    check1("m_flush_ex", flush_ex, e_fex);
    check1("m_mem_req", mem_req, e_req);
    check1("m_mem_we", mem_we, e_we);
    check1("m_mem_err", mem_err, e_err);
    check16("m_sb_pending", sb_pending, e_sb);

    if (reset_n) begin
      for (int r = 0; r < 16; r++) if (wb_valid && int'(wb_rd) == r) m_sb[r] = 0;
      if (e_err && m_mem_ld) m_sb[m_mem_rd] = 0;
      if (e_issue && dst >= 0) m_sb[dst] = 1;
      case (m_mode)
        0: begin
          if (ex_br_taken) begin
            m_mode = 1;
            m_flush_left = FCYC;
          end else if (e_issue && (id_is_ld || id_is_str)) begin
            m_mode = 2; m_mem_age = 1;
            m_mem_str = id_is_str; m_mem_ld = id_is_ld; m_mem_rd = int'(id_rd);
          end
        end
        1: begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = 0;
        end
        default: begin
          if (mem_ack || e_err) m_mode = 0;
          else m_mem_age++;
        end
      endcase
    end
  end

  initial begin
    reset_n = 0;
    idle();
    repeat (2) step();
    #2;
    check16("rst_sb", sb_pending, 16'h0000);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_issue", issue, 1'b0);
    step(); reset_n = 1;

    // RAW stall until the producing register writes back, issue in the writeback cycle
    step(); set_op(OP_ALU, 3, 1, 2, 0); #2; check1("t2_issue_prod", issue, 1'b1);
    step(); set_op(OP_ALU, 4, 3, 0, 0); #2;
    check1("t2_stall", stall_id, 1'b1); check1("t2_hold", issue, 1'b0);
    check16("t2_sb3", sb_pending, 16'h0008);
    step(); #2; check1("t2_stall_again", stall_id, 1'b1);
    step(); wb_valid = 1; wb_rd = 3; #2;
    check1("t2_issue_wb", issue, 1'b1); check1("t2_nostall", stall_id, 1'b0);
    step(); idle(); #2; check16("t2_sb4", sb_pending, 16'h0010);
    step(); wb_valid = 1; wb_rd = 4;

    // Set wins over clear on the same register
    step(); idle(); set_op(OP_ALU, 5, 0, 1, 0); #2; check1("t3_issue_alu", issue, 1'b1);
    step(); set_op(OP_LD, 5, 0, 0, 0); wb_valid = 1; wb_rd = 5; #2;
    check1("t3_issue_ld", issue, 1'b1);
    step(); idle(); mem_ack = 1; #2;
    check16("t3_sb5", sb_pending, 16'h0020);
    check1("t3_mem_req", mem_req, 1'b1); check1("t3_mem_we", mem_we, 1'b0);
    step(); idle(); wb_valid = 1; wb_rd = 5; #2; check1("t3_req_drop", mem_req, 1'b0);

    // Taken branch beats a load in decode
    step(); idle(); set_op(OP_LD, 6, 0, 0, 0); ex_br_taken = 1; #2;
    check1("t4_issue", issue, 1'b0);
    check1("t4_flush_id", flush_id, 1'b1); check1("t4_flush_ex", flush_ex, 1'b1);
    step(); ex_br_taken = 0; #2;
    check1("t4_f1_flush_id", flush_id, 1'b1); check1("t4_f1_flush_ex", flush_ex, 1'b0);
    check1("t4_f1_stall_id", stall_id, 1'b0); check1("t4_f1_req", mem_req, 1'b0);
    step(); #2; check1("t4_f2_flush_id", flush_id, 1'b1); check1("t4_f2_issue", issue, 1'b0);
    step(); #2; check1("t4_run_flush", flush_id, 1'b0); check1("t4_run_issue", issue, 1'b1);
    step(); idle(); mem_ack = 1; #2; check1("t4_req", mem_req, 1'b1);
    step(); idle(); wb_valid = 1; wb_rd = 6;

    // Store handshake with ack in the fourth wait cycle
    step(); idle(); set_op(OP_STR, 2, 1, 0, 0); #2; check1("t5_issue", issue, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(); idle(); set_op(OP_ALU, 8, 9, 10, 0); mem_ack = (k == 4); #2;
      check1("t5_req", mem_req, 1'b1); check1("t5_we", mem_we, 1'b1);
      check1("t5_stall", stall_id, 1'b1); check1("t5_noissue", issue, 1'b0);
    end
    step(); mem_ack = 0; #2;
    check1("t5_req_drop", mem_req, 1'b0); check1("t5_next_issue", issue, 1'b1);
    step(); idle(); wb_valid = 1; wb_rd = 8;

    // Load timeout with no ack
    step(); idle(); set_op(OP_LD, 7, 1, 0, 0); #2; check1("t6_issue", issue, 1'b1);
    for (int k = 1; k <= TMO; k++) begin
      step(); idle(); #2;
      check1("t6_req", mem_req, 1'b1);
      check1("t6_err", mem_err, k == TMO);
      check1("t6_sb7", sb_pending[7], 1'b1);
    end
    step(); #2;
    check1("t6_req_drop", mem_req, 1'b0); check1("t6_err_pulse", mem_err, 1'b0);
    check16("t6_sb_clear", sb_pending, 16'h0000);

    // Asynchronous reset while waiting on memory
    step(); set_op(OP_LD, 9, 0, 0, 0); #2; check1("t1_issue", issue, 1'b1);
    step(); idle(); #2;
    check1("t1_req", mem_req, 1'b1); check16("t1_sb9", sb_pending, 16'h0200);
    step(); idle(); reset_n = 0; #1;
    check1("t1_req_async", mem_req, 1'b0); check16("t1_sb_async", sb_pending, 16'h0000);
    step(); reset_n = 1; #2;
    check1("t1_req_after", mem_req, 1'b0); check16("t1_sb_after", sb_pending, 16'h0000);
    step(); set_op(OP_ALU, 1, 2, 3, 0); #2; check1("t1_run_issue", issue, 1'b1);
    step(); idle(); wb_valid = 1; wb_rd = 1;

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step(); idle();
      set_op(op_e'($urandom_range(0, 7)), rpick(), rpick(), rpick(), 1'($urandom_range(0, 1)));
      id_valid    = ($urandom_range(0, 3) != 0);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_rd       = 4'(rpick());
      ex_br_taken = (m_mode != 1) && ($urandom_range(0, 11) == 0);
      mem_ack     = (m_mode == 2) && ($urandom_range(0, 5) == 0);
    end

    step(); idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
